lvl_state_ctrl: RTL
===================

Name: lvl_state_ctrl

Overview:
Controller on the driving side of the level-state cell chain. It loads per-level states {dcd_bin, has_bkt} from the bin's level-state memory into the chain, writes them back on bin update, and runs the find-backtrack-level sequence. That sequence drives max_lvl and apply_bkt into the chain, collects the backtrack bin and level, and flags the no-backtrack-left (UNSAT) case. It sits between the bin manager and the level-state list.

Parameters:
NUM_LVL, 8, number of level cells in the chain; entry i maps to level i+1.
WIDTH_LVL_STATES, 11, width of one level state {dcd_bin, has_bkt}.
WIDTH_LVL, 16, level number width.
WIDTH_BIN_ID, 10, bin id width.
WIDTH_ADDR, 12, level-state memory address width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start_load_i  in  1  one-cycle request: memory -> chain.
start_save_i  in  1  one-cycle request: chain -> memory.
start_bkt_i  in  1  one-cycle request: find and apply the backtrack level.
base_addr_i  in  WIDTH_ADDR  memory address of entry 0; sampled with start_load_i/start_save_i.
max_lvl_i  in  WIDTH_LVL  current max level; sampled with start_bkt_i.
busy_o  out  1  high while not IDLE.
done_o  out  1  one-cycle pulse at end of any operation.
mem_rd_en_o  out  1  memory read strobe; read data returns 1 cycle later.
mem_wr_en_o  out  1  memory write strobe.
mem_addr_o  out  WIDTH_ADDR  memory address.
mem_wdata_o  out  WIDTH_LVL_STATES  write data.
mem_rdata_i  in  WIDTH_LVL_STATES  read data, valid the cycle after mem_rd_en_o.
wr_states_o  out  1  parallel load strobe to all cells.
lvl_states_all_o  out  NUM_LVL*WIDTH_LVL_STATES  load vector; entry i at bits [i*W +: W].
lvl_states_all_i  in  NUM_LVL*WIDTH_LVL_STATES  current cell states, same packing.
max_lvl_o  out  WIDTH_LVL  max level driven to the chain.
apply_bkt_o  out  1  flips has_bkt of the cell currently flagging findflag==1.
findflag_tail_i  in  2  findflag_o of the last cell in the chain.
bkt_bin_or_i  in  WIDTH_BIN_ID  OR of all cell bkt_bin_o.
bkt_lvl_or_i  in  WIDTH_LVL  OR of all cell bkt_lvl_o.
bkt_valid_o  out  1  result strobe.
bkt_bin_o  out  WIDTH_BIN_ID  backtrack bin.
bkt_lvl_o  out  WIDTH_LVL  backtrack level.
bkt_none_o  out  1  no un-backtracked level is at or below max_lvl (UNSAT).

Behaviour:
- All outputs are registered. On reset, every output is 0 and the FSM returns to IDLE. Reset mid-operation aborts immediately: no further strobes are issued and the partial load vector is discarded.
- States: IDLE, LOAD_RD, LOAD_WR, SAVE_WR, BKT_FIND, BKT_RES.
- Starts are accepted only in IDLE and ignored otherwise. If several starts arrive in the same cycle, priority is load > save > bkt; the losers are dropped.
- Load (start sampled at edge 0):
  - Cycles 1..NUM_LVL: mem_rd_en_o=1, mem_addr_o = base + (cycle-1).
  - Each read data word is captured into entry (cycle-1) on the following cycle.
  - Cycle NUM_LVL+2 (LOAD_WR): wr_states_o=1 and done_o=1 for exactly one cycle, with the full vector on lvl_states_all_o. The vector holds its value after that cycle.
- Save (start sampled at edge 0):
  - lvl_states_all_i is snapshotted at edge 0; later changes are ignored.
  - Cycles 1..NUM_LVL: mem_wr_en_o=1, mem_addr_o = base+i, mem_wdata_o = snapshot entry i.
  - done_o pulses in cycle NUM_LVL+1.
- Address arithmetic is modulo 2^WIDTH_ADDR; wrap-around is legal.
- Backtrack (start sampled at edge 0):
  - Cycle 1 (BKT_FIND): max_lvl_o = sampled max_lvl. Set found = (findflag_tail_i != 0). apply_bkt_o = found in this same cycle.
  - Cycle 2 (BKT_RES): bkt_valid_o=1 and done_o=1. If found, bkt_bin_o/bkt_lvl_o take bkt_bin_or_i/bkt_lvl_or_i and bkt_none_o=0. Otherwise both are 0 and bkt_none_o=1.
  - Result outputs hold until the next bkt start.
  - max_lvl_o is 0 outside BKT_FIND. Levels start at 1, so an idle chain never asserts findflag.
- mem_rd_en_o and mem_wr_en_o are never high together. mem_addr_o and mem_wdata_o are 0 when no strobe is active.
- busy_o is high from cycle 1 through the done_o cycle inclusive.

Test Plan:
- Load, NUM_LVL=8, base=0xFFE, mem[a]=a[10:0]: reads issue to 0xFFE,0xFFF,0x000..0x005; wr_states_o pulses at cycle 10; entry 0 = 0x7FE, entry 2 = 0x000; done_o at cycle 10.
- Save, lvl_states_all_i entry i = {i+3, i[0]}, input changed at cycle 2: 8 writes to base..base+7 carry the snapshot values; done_o at cycle 9.
- Bkt, cells lvl 1..8 with has_bkt = 1,1,0,1,0,0,0,0 and max_lvl=4: apply_bkt_o=1 at cycle 1; result bkt_lvl_o=3, bkt_bin_o = dcd_bin of lvl 3, bkt_none_o=0; lvl 3 has_bkt becomes 1.
- Bkt repeated on the same state with max_lvl=4: now yields bkt_none_o=1, apply_bkt_o=0, bkt_bin_o=0.
- start_load_i and start_bkt_i in the same cycle, then start_save_i during the load: only the load runs; no writes occur.
- rst asserted at load cycle 4: all strobes go to 0 next cycle, busy_o=0, and no wr_states_o pulse follows.

Source files
------------

// File: rtl/lvl_state_ctrl_if.sv
// ============================================================================
// Module   : lvl_state_ctrl_if
// Brief    : Interface bundle for the level-state chain controller. It carries
//            the requests, level-state memory port, chain load/readback and
//            the backtrack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lvl_state_ctrl_if #(
    parameter int NUM_LVL          = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_ADDR       = 12
);
    logic                                  start_load_i;
    logic                                  start_save_i;
    logic                                  start_bkt_i;
    logic [WIDTH_ADDR-1:0]                 base_addr_i;
    logic [WIDTH_LVL-1:0]                  max_lvl_i;
    logic                                  busy_o;
    logic                                  done_o;
    logic                                  mem_rd_en_o;
    logic                                  mem_wr_en_o;
    logic [WIDTH_ADDR-1:0]                 mem_addr_o;
    logic [WIDTH_LVL_STATES-1:0]           mem_wdata_o;
    logic [WIDTH_LVL_STATES-1:0]           mem_rdata_i;
    logic                                  wr_states_o;
    logic [NUM_LVL*WIDTH_LVL_STATES-1:0]   lvl_states_all_o;
    logic [NUM_LVL*WIDTH_LVL_STATES-1:0]   lvl_states_all_i;
    logic [WIDTH_LVL-1:0]                  max_lvl_o;
    logic                                  apply_bkt_o;
    logic [1:0]                            findflag_tail_i;
    logic [WIDTH_BIN_ID-1:0]               bkt_bin_or_i;
    logic [WIDTH_LVL-1:0]                  bkt_lvl_or_i;
    logic                                  bkt_valid_o;
    logic [WIDTH_BIN_ID-1:0]               bkt_bin_o;
    logic [WIDTH_LVL-1:0]                  bkt_lvl_o;
    logic                                  bkt_none_o;

    // Environment side: bin manager, level-state memory and the cell chain.
    modport master (
        output start_load_i, start_save_i, start_bkt_i, base_addr_i, max_lvl_i,
        output mem_rdata_i, lvl_states_all_i, findflag_tail_i, bkt_bin_or_i, bkt_lvl_or_i,
        input  busy_o, done_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
        input  wr_states_o, lvl_states_all_o, max_lvl_o, apply_bkt_o,
        input  bkt_valid_o, bkt_bin_o, bkt_lvl_o, bkt_none_o
    );

    // Controller side.
    modport slave (
        input  start_load_i, start_save_i, start_bkt_i, base_addr_i, max_lvl_i,
        input  mem_rdata_i, lvl_states_all_i, findflag_tail_i, bkt_bin_or_i, bkt_lvl_or_i,
        output busy_o, done_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
        output wr_states_o, lvl_states_all_o, max_lvl_o, apply_bkt_o,
        output bkt_valid_o, bkt_bin_o, bkt_lvl_o, bkt_none_o
    );
endinterface

`default_nettype wire

// File: rtl/lvl_state_ctrl.sv
// ============================================================================
// Module   : lvl_state_ctrl
// Brief    : Drives the level-state cell chain: memory->chain load, chain->memory
//            save, and the find/apply backtrack-level sequence with UNSAT flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvl_state_ctrl #(
    parameter int NUM_LVL          = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_ADDR       = 12
) (
    input  logic            clk,
    input  logic            rst,
    lvl_state_ctrl_if.slave bus
);
    localparam int c_w     = WIDTH_LVL_STATES;
    localparam int c_vec_w = NUM_LVL * WIDTH_LVL_STATES;
    localparam int c_cnt_w = $clog2(NUM_LVL + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_LVL - 1);
    localparam logic [c_cnt_w-1:0] c_num_lvl  = c_cnt_w'(NUM_LVL);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_RD  = 3'd1,
        ST_LOAD_WR  = 3'd2,
        ST_SAVE_WR  = 3'd3,
        ST_BKT_FIND = 3'd4,
        ST_BKT_RES  = 3'd5
    } state_t;

    state_t                    r_state,     w_state;
    logic [c_cnt_w-1:0]        r_cnt,       w_cnt;
    logic [WIDTH_ADDR-1:0]     r_base,      w_base;
    logic [c_vec_w-1:0]        r_buf,       w_buf;
    logic [c_vec_w-1:0]        r_snap,      w_snap;
    logic [c_vec_w-1:0]        r_vec,       w_vec;
    logic                      r_busy,      w_busy;
    logic                      r_done,      w_done;
    logic                      r_rd_en,     w_rd_en;
    logic                      r_wr_en,     w_wr_en;
    logic [WIDTH_ADDR-1:0]     r_addr,      w_addr;
    logic [c_w-1:0]            r_wdata,     w_wdata;
    logic                      r_wr_states, w_wr_states;
    logic [WIDTH_LVL-1:0]      r_max_lvl,   w_max_lvl;
    logic                      r_bkt_valid, w_bkt_valid;
    logic [WIDTH_BIN_ID-1:0]   r_bkt_bin,   w_bkt_bin;
    logic [WIDTH_LVL-1:0]      r_bkt_lvl,   w_bkt_lvl;
    logic                      r_bkt_none,  w_bkt_none;
    logic                      w_found;

    assign w_found = (bus.findflag_tail_i != 2'b00);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_base      = r_base;
        w_buf       = r_buf;
        w_snap      = r_snap;
        w_vec       = r_vec;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_wr_states = 1'b0;
        w_max_lvl   = '0;
        w_bkt_valid = 1'b0;
        w_bkt_bin   = r_bkt_bin;
        w_bkt_lvl   = r_bkt_lvl;
        w_bkt_none  = r_bkt_none;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_load_i) begin
                    w_state = ST_LOAD_RD;
                    w_cnt   = '0;
                    w_base  = bus.base_addr_i;
                    w_buf   = '0;
                    w_rd_en = 1'b1;
                    w_addr  = bus.base_addr_i;
                end else if (bus.start_save_i) begin
                    w_state = ST_SAVE_WR;
                    w_cnt   = '0;
                    w_base  = bus.base_addr_i;
                    w_snap  = bus.lvl_states_all_i;
                    w_wr_en = 1'b1;
                    w_addr  = bus.base_addr_i;
                    w_wdata = bus.lvl_states_all_i[c_w-1:0];
                end else if (bus.start_bkt_i) begin
                    w_state   = ST_BKT_FIND;
                    w_max_lvl = bus.max_lvl_i;
                end
            end

            // r_cnt is (cycle - 1); read data for entry r_cnt-1 is on the bus now.
            ST_LOAD_RD: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt != '0) begin
                    w_buf[(int'(r_cnt) - 1) * c_w +: c_w] = bus.mem_rdata_i;
                end
                if (r_cnt < c_last_idx) begin
                    w_rd_en = 1'b1;
                    w_addr  = r_base + WIDTH_ADDR'(r_cnt + 1'b1);
                end
                if (r_cnt == c_num_lvl) begin
                    w_state     = ST_LOAD_WR;
                    w_vec       = w_buf;
                    w_wr_states = 1'b1;
                    w_done      = 1'b1;
                end
            end

            ST_LOAD_WR: begin
                w_state = ST_IDLE;
            end

            ST_SAVE_WR: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt < c_last_idx) begin
                    w_wr_en = 1'b1;
                    w_addr  = r_base + WIDTH_ADDR'(r_cnt + 1'b1);
                    w_wdata = r_snap[(int'(r_cnt) + 1) * c_w +: c_w];
                end
                if (r_cnt == c_last_idx) begin
                    w_done = 1'b1;
                end
                if (r_cnt == c_num_lvl) begin
                    w_state = ST_IDLE;
                end
            end

            // Chain answers combinationally to max_lvl_o during this cycle.
            ST_BKT_FIND: begin
                w_state     = ST_BKT_RES;
                w_bkt_valid = 1'b1;
                w_done      = 1'b1;
                w_bkt_bin   = w_found ? bus.bkt_bin_or_i : '0;
                w_bkt_lvl   = w_found ? bus.bkt_lvl_or_i : '0;
                w_bkt_none  = ~w_found;
            end

            ST_BKT_RES: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_buf       <= '0;
            r_snap      <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr_states <= 1'b0;
            r_max_lvl   <= '0;
            r_bkt_valid <= 1'b0;
            r_bkt_bin   <= '0;
            r_bkt_lvl   <= '0;
            r_bkt_none  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_base      <= w_base;
            r_buf       <= w_buf;
            r_snap      <= w_snap;
            r_vec       <= w_vec;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_rd_en     <= w_rd_en;
            r_wr_en     <= w_wr_en;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_wr_states <= w_wr_states;
            r_max_lvl   <= w_max_lvl;
            r_bkt_valid <= w_bkt_valid;
            r_bkt_bin   <= w_bkt_bin;
            r_bkt_lvl   <= w_bkt_lvl;
            r_bkt_none  <= w_bkt_none;
        end
    end

    assign bus.busy_o           = r_busy;
    assign bus.done_o           = r_done;
    assign bus.mem_rd_en_o      = r_rd_en;
    assign bus.mem_wr_en_o      = r_wr_en;
    assign bus.mem_addr_o       = r_addr;
    assign bus.mem_wdata_o      = r_wdata;
    assign bus.wr_states_o      = r_wr_states;
    assign bus.lvl_states_all_o = r_vec;
    assign bus.max_lvl_o        = r_max_lvl;
    // The flip must land on the same edge that closes the find cycle.
    assign bus.apply_bkt_o      = (r_state == ST_BKT_FIND) && w_found;
    assign bus.bkt_valid_o      = r_bkt_valid;
    assign bus.bkt_bin_o        = r_bkt_bin;
    assign bus.bkt_lvl_o        = r_bkt_lvl;
    assign bus.bkt_none_o       = r_bkt_none;

endmodule

`default_nettype wire
